// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI master bridge.
// One transfer in flight; out-of-window accesses answer with wb_err_o.
module wb_obi_bridge #(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               WINDOW_BITS = 24,
  parameter logic [ADDR_W-1:0] OBI_BASE   = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [ADDR_W-1:0]   obi_addr_o,
  output logic                obi_we_o,
  output logic [DATA_W/8-1:0] obi_be_o,
  output logic [DATA_W-1:0]   obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [DATA_W-1:0]   obi_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACK, S_ERR
  } state_t;

  state_t r_state;
  logic   r_abort;

  logic              w_stb;
  logic              w_oow;
  logic              w_abort;
  logic [ADDR_W-1:0] w_addr;

  assign w_stb   = wb_cyc_i & wb_stb_i;
  assign w_oow   = |wb_adr_i[ADDR_W-1:WINDOW_BITS];
  assign w_abort = r_abort | ~wb_cyc_i;
  assign w_addr  = OBI_BASE |
    {{(ADDR_W-WINDOW_BITS){1'b0}}, wb_adr_i[WINDOW_BITS-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_abort     <= 1'b0;
      obi_req_o   <= 1'b0;
      obi_addr_o  <= '0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_wdata_o <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (w_stb) begin
            obi_addr_o  <= w_addr;
            obi_we_o    <= wb_we_i;
            obi_be_o    <= wb_sel_i;
            obi_wdata_o <= wb_dat_i;
            if (w_oow) begin
              r_state  <= S_ERR;
              wb_err_o <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              obi_req_o <= 1'b1;
            end
          end
        end
        // OBI forbids retracting req, so an abort only marks the result
        S_REQ: begin
          if (!wb_cyc_i) r_abort <= 1'b1;
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) r_abort <= 1'b1;
          if (obi_rvalid_i) begin
            if (!obi_we_o && !w_abort) wb_dat_o <= obi_rdata_i;
            if (w_abort) begin
              r_state <= S_IDLE;
              r_abort <= 1'b0;
            end else begin
              r_state  <= S_ACK;
              wb_ack_o <= 1'b1;
            end
          end
        end
        S_ACK: begin
          wb_ack_o <= 1'b0;
          r_abort  <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_ERR: begin
          wb_err_o <= 1'b0;
          r_abort  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_obi_bridge.md
Name: wb_obi_bridge

Overview:
Wishbone slave to OBI master bridge; the reverse path of the OBI-to-Wishbone bridge. Lets Smartwave-side Wishbone masters (pattern engines, debug access) reach SoC memory/peripherals on the OBI bus through a fixed address window. Handles one transfer at a time, registers all OBI request attributes, returns the OBI response as a Wishbone classic ack, and flags out-of-window accesses with wb_err_o.

Parameters:
ADDR_W, 32, address width on both buses
DATA_W, 32, data width on both buses
WINDOW_BITS, 24, size of the Wishbone window in address bits (16 MiB)
OBI_BASE, 32'h0000_0000, OBI base address; its low WINDOW_BITS bits must be 0

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write, 0 = read
wb_sel_i  in  DATA_W/8  byte select
wb_adr_i  in  ADDR_W  Wishbone byte address
wb_dat_i  in  DATA_W  write data
wb_dat_o  out  DATA_W  read data, valid while wb_ack_o = 1
wb_ack_o  out  1  transfer complete
wb_err_o  out  1  transfer rejected (out of window)
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ADDR_W  OBI address
obi_we_o  out  1  OBI write enable
obi_be_o  out  DATA_W/8  OBI byte enable
obi_wdata_o  out  DATA_W  OBI write data
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  DATA_W  OBI read data

Behaviour:
- Reset (rst_i = 1 at a clock edge): state IDLE. All outputs 0. Abort flag cleared. Reset mid-transfer drops everything; no ack or err is issued.
- States: IDLE, REQ, WAIT, ACK, ERR.
- IDLE:
  - cyc&stb with wb_adr_i[ADDR_W-1:WINDOW_BITS] != 0 -> ERR.
  - cyc&stb otherwise -> REQ.
  - In both cases, register obi_addr_o = OBI_BASE | wb_adr_i[WINDOW_BITS-1:0], obi_we_o = wb_we_i, obi_be_o = wb_sel_i, obi_wdata_o = wb_dat_i.
- REQ:
  - obi_req_o = 1. Address, we, be and wdata are held stable until the grant.
  - On obi_gnt_i -> WAIT. obi_req_o drops the cycle after the grant.
- WAIT:
  - On obi_rvalid_i: capture obi_rdata_i into wb_dat_o (reads only; writes keep the previous value).
  - Then go to ACK, or to IDLE if the abort flag is set.
- ACK: wb_ack_o = 1 for exactly one cycle -> IDLE.
- ERR: wb_err_o = 1 for exactly one cycle. No OBI activity -> IDLE.
- Only one transfer is outstanding. rvalid in IDLE/REQ/ACK/ERR is ignored. rvalid never arrives in the grant cycle (OBI rule).
- Latency with gnt and rvalid immediate: stb sampled at edge N; req at N+1, rvalid at N+2, ack at N+3. Each gnt or rvalid wait cycle adds 1.
- Abort: cyc_i low while in REQ or WAIT sets the abort flag. obi_req_o is NOT retracted, since OBI forbids it. The OBI transfer completes, its result is discarded and no ack is given. The flag is cleared on entry to IDLE.
- Master holding stb in the cycle after ack/err (non-classic master): IDLE samples it as a new transfer. Classic masters must drop stb after ack.
- wb_sel_i = 0 is forwarded unchanged (be = 0); the bridge does not special-case it.
- Address arithmetic is an OR with OBI_BASE; no carry, no wrap. Bit WINDOW_BITS and above of the WB address only select err.

Test Plan:
- Read with gnt same cycle, rvalid next: stb on adr 32'h0000_1004, OBI_BASE 32'h2000_0000, rdata 32'hDEAD_BEEF -> obi_addr_o 32'h2000_1004, we 0; ack 3 cycles after stb with wb_dat_o 32'hDEAD_BEEF.
- Write with gnt delayed 4 cycles: wdata 32'hA5A5_0F0F, sel 4'b0110 -> req held 5 cycles with stable addr/be/wdata; obi_be_o 4'b0110; single ack after rvalid.
- Out of window: adr 32'h0100_0000 -> wb_err_o pulses 1 cycle after stb; obi_req_o stays 0; wb_ack_o stays 0.
- Abort: cyc drops 1 cycle into a REQ waiting 3 cycles for gnt -> req stays high until gnt; rvalid consumed; no ack; next transfer completes normally.
- Reset during WAIT: rst_i high 1 cycle -> all outputs 0 next cycle; a late rvalid is ignored; no ack.
- Back-to-back: 10 classic reads with random gnt/rvalid delays (0–5 cycles) -> 10 acks, data in order, never more than one OBI transfer outstanding.
